wdata_chan_mngr: RTL and testbench

- Write data channel manager: the transmitting end of the write data channel.
- Accepts one 128-bit line plus a 16-bit byte mask from the cache/CPU side and drives it as a burst of up to 4 32-bit beats (wvalid/wready/wdata/wstrb/wlast).
- Sits opposite wdat_s-style subordinates on the bus.
- Mask polarity matches the subordinate side: mask bit 1 = byte not written.

---
 rtl/wdata_chan_mngr_pkg.sv | 30 +++
 rtl/wdata_chan_mngr_if.sv | 27 ++
 rtl/wdat_beat_sel.sv | 24 ++
 rtl/wdata_chan_mngr.sv | 66 ++++++
 tb/tb_wdata_chan_mngr.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/wdata_chan_mngr_pkg.sv
// rtl/wdata_chan_mngr_pkg.sv - shared write-data channel definitions
package wdata_chan_mngr_pkg;

  localparam int BEAT_W    = 32;
  localparam int STRB_W    = 4;
  localparam int MAX_BURST = 4;
  localparam int LINE_W    = BEAT_W * MAX_BURST;
  localparam int MASK_W    = STRB_W * MAX_BURST;
  localparam int LEN_W     = 2;

  // Mask polarity: bit = 1 means the byte is NOT written; wstrb is its complement.
  typedef enum logic [1:0] {
    WDAT_MIDLE = 2'b00,
    WDAT_MSEND = 2'b01,
    WDAT_MDEFO = 2'b11
  } wdat_mstate_e;

  typedef enum logic [1:0] {
    WDAT_SIDLE = 2'b00,
    WDAT_SRECV = 2'b01,
    WDAT_SDEFO = 2'b11
  } wdat_sstate_e;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [MASK_W-1:0] mask;
    logic [LEN_W-1:0]  len;
  } wdat_buf_t;

endpackage

// File: rtl/wdata_chan_mngr_if.sv
// rtl/wdata_chan_mngr_if.sv - request side and bus write-data channel signals
interface wdata_chan_mngr_if;
  import wdata_chan_mngr_pkg::*;

  logic              wdat_m_valid;
  logic              wdat_m_ready;
  logic [LINE_W-1:0] wdat_m_data;
  logic [MASK_W-1:0] wdat_m_mask;
  logic [LEN_W-1:0]  wdat_m_len;
  logic              wvalid;
  logic              wready;
  logic [BEAT_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              finish_mwd;

  modport master (
    input  wdat_m_valid, wdat_m_data, wdat_m_mask, wdat_m_len, wready,
    output wdat_m_ready, wvalid, wdata, wstrb, wlast, finish_mwd
  );

  modport slave (
    output wdat_m_valid, wdat_m_data, wdat_m_mask, wdat_m_len, wready,
    input  wdat_m_ready, wvalid, wdata, wstrb, wlast, finish_mwd
  );

endinterface

// File: rtl/wdat_beat_sel.sv
// rtl/wdat_beat_sel.sv - picks the current beat's data and strobe from the line buffer
module wdat_beat_sel
  import wdata_chan_mngr_pkg::*;
(
  input  logic [LINE_W-1:0] data,
  input  logic [MASK_W-1:0] mask,
  input  logic [1:0]        sel,
  output logic [BEAT_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb
);

  always_comb begin
    wdata = data[31:0];
    wstrb = ~mask[3:0];
    case (sel)
      2'd0: begin wdata = data[31:0];   wstrb = ~mask[3:0];   end
      2'd1: begin wdata = data[63:32];  wstrb = ~mask[7:4];   end
      2'd2: begin wdata = data[95:64];  wstrb = ~mask[11:8];  end
      2'd3: begin wdata = data[127:96]; wstrb = ~mask[15:12]; end
      default: ;
    endcase
  end

endmodule

// File: rtl/wdata_chan_mngr.sv
// rtl/wdata_chan_mngr.sv - buffers one masked line and sends it as a burst of up to four beats
module wdata_chan_mngr
  import wdata_chan_mngr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  wdata_chan_mngr_if.master bus
);

  wdat_mstate_e state_q, state_d;
  wdat_buf_t    buf_q;
  logic [1:0]   cnt_q;
  logic         finish_q;
  logic         accept;
  logic         beat_hs;
  logic         last_hs;

  assign bus.wdat_m_ready = (state_q == WDAT_MIDLE);
  assign bus.wvalid       = (state_q == WDAT_MSEND);
  assign bus.wlast        = bus.wvalid & (cnt_q == buf_q.len);
  assign bus.finish_mwd   = finish_q;

  assign accept  = bus.wdat_m_valid & bus.wdat_m_ready;
  assign beat_hs = bus.wvalid & bus.wready;
  assign last_hs = beat_hs & bus.wlast;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WDAT_MIDLE: if (bus.wdat_m_valid) state_d = WDAT_MSEND;
      WDAT_MSEND: if (last_hs) state_d = WDAT_MIDLE;
      WDAT_MDEFO: state_d = WDAT_MDEFO;
      default:    state_d = WDAT_MDEFO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WDAT_MIDLE;
      buf_q    <= '{data: '0, mask: '1, len: '0};
      cnt_q    <= 2'd0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= last_hs;
      if (accept) begin
        buf_q <= '{data: bus.wdat_m_data, mask: bus.wdat_m_mask, len: bus.wdat_m_len};
        cnt_q <= 2'd0;
      end else if (last_hs) begin
        cnt_q <= 2'd0;
      end else if (beat_hs) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Reset buffer (data 0, mask all-ones) makes the idle bus show wdata 0 / wstrb 0.
  wdat_beat_sel u_beat_sel (
    .data  (buf_q.data),
    .mask  (buf_q.mask),
    .sel   (cnt_q),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb)
  );

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// tb/tb_wdata_chan_mngr.sv - directed self-checking bench for wdata_chan_mngr
module tb_wdata_chan_mngr;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  wdata_chan_mngr_if bus ();

  wdata_chan_mngr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] d, input logic [3:0] s,
                          input logic l);
    chk({tag, ".wvalid"}, 128'(bus.wvalid), 128'(1'b1));
    chk({tag, ".wdata"},  128'(bus.wdata),  128'(d));
    chk({tag, ".wstrb"},  128'(bus.wstrb),  128'(s));
    chk({tag, ".wlast"},  128'(bus.wlast),  128'(l));
  endtask

  task automatic send(input logic [127:0] d, input logic [15:0] m, input logic [1:0] l);
    bus.wdat_m_valid = 1'b1;
    bus.wdat_m_data  = d;
    bus.wdat_m_mask  = m;
    bus.wdat_m_len   = l;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".wvalid"}, 128'(bus.wvalid),       128'(1'b0));
    chk({tag, ".wlast"},  128'(bus.wlast),        128'(1'b0));
    chk({tag, ".wdata"},  128'(bus.wdata),        128'(32'h0));
    chk({tag, ".wstrb"},  128'(bus.wstrb),        128'(4'h0));
    chk({tag, ".ready"},  128'(bus.wdat_m_ready), 128'(1'b1));
  endtask

  logic [127:0] d1, d2, d4a, d4b, d5;

  initial begin
    d1  = 128'h44444444_33333333_22222222_11111111;
    d2  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    d4a = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
    d4b = 128'h99999999_88888888_77777777_CAFEF00D;
    d5  = 128'h0_0_0_0_0_0_12345678_87654321;

    rst_n = 1'b0;
    bus.wdat_m_valid = 1'b0;
    bus.wdat_m_data  = '0;
    bus.wdat_m_mask  = '0;
    bus.wdat_m_len   = '0;
    bus.wready       = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_reset("rst");
    chk("rst.finish", 128'(bus.finish_mwd), 128'(1'b0));
    rst_n = 1'b1;
    bus.wready = 1'b1;
    @(negedge clk);
    chk("idle_wready.wvalid", 128'(bus.wvalid), 128'(1'b0));

    // Full burst, wready tied high
    send(d1, 16'h0000, 2'd3);
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    chk("full.ready_busy", 128'(bus.wdat_m_ready), 128'(1'b0));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk_beat($sformatf("full.b%0d", i), d1[32*i +: 32], 4'hF, i == 3);
      chk($sformatf("full.fin%0d", i), 128'(bus.finish_mwd), 128'(1'b0));
    end
    @(negedge clk);
    chk("full.finish", 128'(bus.finish_mwd), 128'(1'b1));
    chk("full.ready",  128'(bus.wdat_m_ready), 128'(1'b1));
    chk("full.wvalid_end", 128'(bus.wvalid), 128'(1'b0));
    @(negedge clk);
    chk("full.finish_once", 128'(bus.finish_mwd), 128'(1'b0));

    // Backpressure: second beat held for three cycles
    send(d2, 16'h1234, 2'd3);
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    chk_beat("bp.b0", 32'hA0A0A0A0, 4'hB, 1'b0);
    @(negedge clk);
    chk_beat("bp.b1", 32'hA1A1A1A1, 4'hC, 1'b0);
    bus.wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_beat($sformatf("bp.hold%0d", i), 32'hA1A1A1A1, 4'hC, 1'b0);
    end
    bus.wready = 1'b1;
    @(negedge clk);
    chk_beat("bp.b2", 32'hA2A2A2A2, 4'hD, 1'b0);
    @(negedge clk);
    chk_beat("bp.b3", 32'hA3A3A3A3, 4'hE, 1'b1);
    @(negedge clk);
    chk("bp.finish", 128'(bus.finish_mwd), 128'(1'b1));
    chk("bp.wvalid_end", 128'(bus.wvalid), 128'(1'b0));

    // Short bursts, including an all-masked beat
    send({96'h5555_5555_6666_6666_7777_7777, 32'hDEADBEEF}, 16'hFFF0, 2'd0);
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    chk_beat("s0.b0", 32'hDEADBEEF, 4'hF, 1'b1);
    @(negedge clk);
    chk("s0.finish", 128'(bus.finish_mwd), 128'(1'b1));
    chk("s0.wvalid_end", 128'(bus.wvalid), 128'(1'b0));
    send(d1, 16'h00A5, 2'd1);
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    chk_beat("s1.b0", 32'h11111111, 4'hA, 1'b0);
    @(negedge clk);
    chk_beat("s1.b1", 32'h22222222, 4'h5, 1'b1);
    @(negedge clk);
    chk("s1.finish", 128'(bus.finish_mwd), 128'(1'b1));
    send(d2, 16'h00F0, 2'd1);
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    chk_beat("sm.b0", 32'hA0A0A0A0, 4'hF, 1'b0);
    @(negedge clk);
    chk_beat("sm.b1", 32'hA1A1A1A1, 4'h0, 1'b1);
    @(negedge clk);

    // Request while busy is ignored, then accepted in the finish cycle
    send(d4a, 16'h0000, 2'd3);
    @(negedge clk);
    send(d4b, 16'h000F, 2'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk_beat($sformatf("busy.b%0d", i), d4a[32*i +: 32], 4'hF, i == 3);
    end
    @(negedge clk);
    chk("busy.finish", 128'(bus.finish_mwd), 128'(1'b1));
    chk("busy.ready",  128'(bus.wdat_m_ready), 128'(1'b1));
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    chk_beat("busy.next_b0", 32'hCAFEF00D, 4'h0, 1'b1);
    @(negedge clk);
    chk("busy.next_finish", 128'(bus.finish_mwd), 128'(1'b1));

    // Reset in the middle of a burst
    send(d1, 16'h0000, 2'd3);
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_beat("mid.b2", 32'h33333333, 4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_idle_reset("mid.rst");
    @(negedge clk);
    rst_n = 1'b1;
    send(d5, 16'h0000, 2'd1);
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    chk_beat("mid.new_b0", 32'h87654321, 4'hF, 1'b0);
    @(negedge clk);
    chk_beat("mid.new_b1", 32'h12345678, 4'hF, 1'b1);
    @(negedge clk);
    chk("mid.new_finish", 128'(bus.finish_mwd), 128'(1'b1));

    // Back-to-back with the request held valid
    send(d1, 16'h0000, 2'd1);
    @(negedge clk);
    send(d2, 16'h0000, 2'd0);
    chk_beat("b2b.p0", 32'h11111111, 4'hF, 1'b0);
    @(negedge clk);
    chk_beat("b2b.p1", 32'h22222222, 4'hF, 1'b1);
    @(negedge clk);
    chk("b2b.gap_wvalid", 128'(bus.wvalid), 128'(1'b0));
    chk("b2b.fin1", 128'(bus.finish_mwd), 128'(1'b1));
    @(negedge clk);
    bus.wdat_m_valid = 1'b0;
    chk_beat("b2b.q0", 32'hA0A0A0A0, 4'hF, 1'b1);
    chk("b2b.fin1_once", 128'(bus.finish_mwd), 128'(1'b0));
    @(negedge clk);
    chk("b2b.fin2", 128'(bus.finish_mwd), 128'(1'b1));
    @(negedge clk);
    chk("b2b.fin2_once", 128'(bus.finish_mwd), 128'(1'b0));
    chk("b2b.idle", 128'(bus.wvalid), 128'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
